// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one stall-handshake cache between the fetch (I)
// and load/store (D) ports, with registered completion and saturating hit/miss counters.
module cache_port_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [9:0]       i_addr,
    output logic             i_done,
    output logic [31:0]      i_rdata,
    input  logic             d_valid,
    output logic             d_ready,
    input  logic             d_we,
    input  logic [9:0]       d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_done,
    output logic [31:0]      d_rdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [9:0]       word_address,
    output logic [31:0]      data_in,
    input  logic             stall,
    input  logic [31:0]      data_out,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              stalled_q, stalled_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [9:0]        word_address_q, word_address_d;
    logic [31:0]       data_in_q, data_in_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    always_comb begin
        state_d        = state_q;
        last_d_d       = last_d_q;
        stalled_d      = stalled_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        word_address_d = word_address_q;
        data_in_d      = data_in_q;
        i_done_d       = 1'b0;
        d_done_d       = 1'b0;
        i_rdata_d      = i_rdata_q;
        d_rdata_d      = d_rdata_q;
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        i_ready        = 1'b0;
        d_ready        = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the port that did not own the cache last time wins.
                i_ready = i_valid && (!d_valid || last_d_q);
                d_ready = d_valid && (!i_valid || !last_d_q);
                if (i_ready) begin
                    word_address_d = i_addr;
                    mem_read_d     = 1'b1;
                    mem_write_d    = 1'b0;
                    last_d_d       = 1'b0;
                    stalled_d      = 1'b0;
                    state_d        = BUSY_I;
                end else if (d_ready) begin
                    word_address_d = d_addr;
                    data_in_d      = d_wdata;
                    mem_read_d     = !d_we;
                    mem_write_d    = d_we;
                    last_d_d       = 1'b1;
                    stalled_d      = 1'b0;
                    state_d        = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (stall) begin
                    stalled_d = 1'b1;
                end else begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = IDLE;
                    if (state_q == BUSY_I) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = data_out;
                    end else begin
                        d_done_d = 1'b1;
                        if (mem_read_q) begin
                            d_rdata_d = data_out;
                        end
                    end
                    // Completion cycle has stall=0, so only earlier stalls count.
                    if (stalled_q) begin
                        if (miss_cnt_q != {CNT_W{1'b1}}) begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end else if (hit_cnt_q != {CNT_W{1'b1}}) begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_d_q       <= 1'b1;
            stalled_q      <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            word_address_q <= '0;
            data_in_q      <= '0;
            i_done_q       <= 1'b0;
            d_done_q       <= 1'b0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            last_d_q       <= last_d_d;
            stalled_q      <= stalled_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            word_address_q <= word_address_d;
            data_in_q      <= data_in_d;
            i_done_q       <= i_done_d;
            d_done_q       <= d_done_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
            hit_cnt_q      <= hit_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign word_address = word_address_q;
    assign data_in      = data_in_q;
    assign i_done       = i_done_q;
    assign d_done       = d_done_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single unified cache (10-bit word address, 32-bit data, stall-based handshake) between two requesters: the instruction-fetch port (port I, read-only) and the load/store port (port D, read/write).
- Arbitrates with round-robin priority and latches the winning request.
- Drives the cache request signals stable until the cache drops stall, then returns registered read data and a one-cycle done pulse to the owner.
- Sits between the core's fetch/LSU front ends and the cache top; also keeps saturating hit/miss counters.

Parameters:
- CNT_W, 16, width of the hit and miss performance counters (saturating).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- i_valid  input  1  fetch request valid
- i_ready  output  1  fetch request accepted this cycle (combinational)
- i_addr  input  10  fetch word address
- i_done  output  1  fetch complete pulse (registered)
- i_rdata  output  32  fetched word, valid when i_done=1, held until next i_done
- d_valid  input  1  load/store request valid
- d_ready  output  1  load/store request accepted this cycle (combinational)
- d_we  input  1  1=store, 0=load
- d_addr  input  10  load/store word address
- d_wdata  input  32  store data
- d_done  output  1  load/store complete pulse (registered)
- d_rdata  output  32  load data, valid when d_done=1 after a load, held otherwise
- mem_read  output  1  cache read request
- mem_write  output  1  cache write request
- word_address  output  10  cache word address
- data_in  output  32  cache write data
- stall  input  1  cache stall (miss or write in progress)
- data_out  input  32  cache read data, valid in a cycle where a read is asserted and stall=0
- hit_cnt  output  CNT_W  accesses completed with zero stall cycles
- miss_cnt  output  CNT_W  accesses completed after at least one stall cycle

Behaviour:
- Reset (rst_n=0 at clock edge) takes effect at that edge, including mid-transaction:
  - state=IDLE; mem_read=mem_write=0; word_address=0; data_in=0.
  - i_done=d_done=0; i_rdata=d_rdata=0; hit_cnt=miss_cnt=0; last_owner=D; stalled flag=0.
  - The in-flight access is abandoned with no done pulse.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration (combinational):
  - Only i_valid: i_ready=1.
  - Only d_valid: d_ready=1.
  - Both valid: grant the port that is not last_owner. After reset, I wins the first tie.
  - At most one ready is high at a time. Both readies are 0 outside IDLE.
- Accept (valid & ready at an edge):
  - Latch addr into word_address; for D also latch d_wdata into data_in.
  - Set mem_read=1 (I, or D with d_we=0) or mem_write=1 (D with d_we=1).
  - Set last_owner; go to BUSY_x; clear the stalled flag.
  - Cache signals become visible the cycle after accept.
- BUSY_x:
  - mem_read, mem_write, word_address and data_in are held constant.
  - Each cycle with stall=1 sets the stalled flag.
  - The first cycle with stall=0 is the completion cycle. At its edge:
    - capture data_out into x_rdata (reads only; stores leave d_rdata unchanged);
    - assert x_done for exactly one cycle;
    - drop mem_read/mem_write to 0;
    - return to IDLE;
    - increment miss_cnt if the stalled flag is set or stall was seen this cycle, else increment hit_cnt.
- Latency: accept edge T, cache request driven T..T+1. A hit completes at edge T+1, so done is high in cycle T+1..T+2. Each stall cycle adds 1.
- Back-to-back: in the done cycle the FSM is in IDLE and may accept a new request. The maximum throughput is one access per 2 cycles.
- mem_read and mem_write are never both 1. Both are 0 in IDLE.
- Counters saturate at 2^CNT_W-1 (no wrap).
- Requesters may change or drop valid and address freely when not ready; there are no protocol assumptions beyond the valid/ready handshake.

Test Plan:
- Reset then i_valid=1, i_addr=0x005, cache hit (stall=0), data_out=0xDEADBEEF → i_ready=1 in cycle 0; mem_read=1, word_address=0x005 in cycle 1; i_done=1 with i_rdata=0xDEADBEEF in cycle 2; hit_cnt=1.
- d_valid=1, d_we=1, d_addr=0x3FF, d_wdata=0x12345678, stall held high 4 cycles → mem_write=1 and data_in stable for 5 cycles; d_done pulses once; d_rdata unchanged; miss_cnt=1.
- i_valid and d_valid both held high continuously, all hits → grants alternate I,D,I,D starting with I; each done pulse arrives 2 cycles after its ready; never two readies in one cycle.
- Load miss: d_addr=0x080, stall=1 for 3 cycles, then data_out=0xA5A5A5A5 → d_done with d_rdata=0xA5A5A5A5 at the completion edge +1; i_valid arriving during BUSY_D sees i_ready=0 until IDLE.
- rst_n=0 for one edge during a stalled BUSY_I → next cycle mem_read=0, i_done never pulses, counters 0; the next tie is granted to I.
- CNT_W=2, 5 consecutive hits → hit_cnt stops at 3.
